// File: rtl/pokey_clk_enable_gen_if.sv
// POKEY master-clock enable bundle.
// init flows into the generator; the enables flow out.
interface pokey_clk_enable_gen_if;
  logic init;
  logic clk179;
  logic enp;
  logic enn;
  logic en64;
  logic en15;

  modport master (
    output init,
    input  clk179, enp, enn, en64, en15
  );

  modport slave (
    input  init,
    output clk179, enp, enn, en64, en15
  );
endinterface

// File: rtl/pokey_clk_enable_gen.sv
// POKEY 1.79 MHz edge enables from a fractional phase accumulator,
// plus the 64 kHz / 15 kHz base-clock enables derived from enp.
module pokey_clk_enable_gen #(
  parameter int ACC_W = 24,
  parameter int INC   = 1201096,
  parameter int DIV64 = 28,
  parameter int DIV15 = 114
) (
  input logic clk,
  input logic reset,
  pokey_clk_enable_gen_if.slave bus
);

  localparam int W64 = (DIV64 > 1) ? $clog2(DIV64) : 1;
  localparam int W15 = (DIV15 > 1) ? $clog2(DIV15) : 1;
  localparam logic [ACC_W:0]  INC_X = (ACC_W+1)'(INC);
  localparam logic [W64-1:0]  TC64  = W64'(DIV64 - 1);
  localparam logic [W15-1:0]  TC15  = W15'(DIV15 - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             phase;
  logic             carry;
  logic             rise;
  logic             fall;

  logic [W64-1:0]   div64;
  logic [W64-1:0]   div64_nxt;
  logic             hit64;
  logic [W15-1:0]   div15;
  logic [W15-1:0]   div15_nxt;
  logic             hit15;

  always_comb begin
    sum   = {1'b0, acc} + INC_X;
    carry = sum[ACC_W];
    rise  = carry & ~phase;
    fall  = carry & phase;
  end

  // init outranks a terminal-count enp in the same clk
  always_comb begin
    div64_nxt = div64;
    hit64     = 1'b0;
    if (bus.init) begin
      div64_nxt = '0;
    end else if (rise) begin
      if (div64 == TC64) begin
        div64_nxt = '0;
        hit64     = 1'b1;
      end else begin
        div64_nxt = div64 + W64'(1);
      end
    end
  end

  always_comb begin
    div15_nxt = div15;
    hit15     = 1'b0;
    if (bus.init) begin
      div15_nxt = '0;
    end else if (rise) begin
      if (div15 == TC15) begin
        div15_nxt = '0;
        hit15     = 1'b1;
      end else begin
        div15_nxt = div15 + W15'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      phase    <= 1'b0;
      div64    <= '0;
      div15    <= '0;
      bus.enp  <= 1'b0;
      bus.enn  <= 1'b0;
      bus.en64 <= 1'b0;
      bus.en15 <= 1'b0;
    end else begin
      acc      <= sum[ACC_W-1:0];
      if (carry)
        phase  <= ~phase;
      div64    <= div64_nxt;
      div15    <= div15_nxt;
      bus.enp  <= rise;
      bus.enn  <= fall;
      bus.en64 <= hit64;
      bus.en15 <= hit15;
    end
  end

  assign bus.clk179 = phase;

endmodule

// File: tb/tb_pokey_clk_enable_gen.sv
// Bench for pokey_clk_enable_gen: arithmetic carry-count model
// checked every clk, plus directed literal expectations.
module tb_pokey_clk_enable_gen;

  localparam int     ACC_W = 24;
  localparam longint MODV  = 64'd1 << ACC_W;
  localparam int     INC_A = 1 << 22;
  localparam int     INC_B = 1201096;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  pokey_clk_enable_gen_if a_if ();
  pokey_clk_enable_gen_if b_if ();

  pokey_clk_enable_gen #(.INC(INC_A)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (a_if)
  );

  pokey_clk_enable_gen #(.INC(INC_B)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (b_if)
  );

  task automatic check(input string nm, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_rng(input string nm, input longint got,
                           input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: after n clks since release the number of carries is
  // floor(n*INC / 2^ACC_W); odd-numbered carries are rising edges.
  longint     n   [2];
  longint     k64 [2];
  longint     k15 [2];
  logic [4:0] ex  [2];

  task automatic model_step(input int d, input logic r, input logic ini,
                            input longint inc);
    longint c;
    longint p;
    logic   cy;
    logic   ep;
    logic   e64;
    logic   e15;
    if (r) begin
      n[d]   = 0;
      k64[d] = 0;
      k15[d] = 0;
      ex[d]  = '0;
    end else begin
      n[d]++;
      c   = (n[d] * inc) / MODV;
      p   = ((n[d] - 1) * inc) / MODV;
      cy  = (c != p);
      ep  = cy && (c % 2 == 1);
      e64 = 1'b0;
      e15 = 1'b0;
      if (ini) begin
        k64[d] = 0;
        k15[d] = 0;
      end else if (ep) begin
        k64[d]++;
        k15[d]++;
        e64 = (k64[d] % 28 == 0);
        e15 = (k15[d] % 114 == 0);
      end
      ex[d] = {c[0], ep, cy && !ep, e64, e15};
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; k64[d] = 0; k15[d] = 0; ex[d] = '0;
    end
  end

  always @(posedge clk) begin
    model_step(0, rst_a, a_if.init, INC_A);
    model_step(1, rst_b, b_if.init, INC_B);
  end

  always @(negedge clk) begin
    check("model_a",
          {a_if.clk179, a_if.enp, a_if.enn, a_if.en64, a_if.en15},
          rst_a ? 5'b0 : ex[0]);
    check("model_b",
          {b_if.clk179, b_if.enp, b_if.enn, b_if.en64, b_if.en15},
          rst_b ? 5'b0 : ex[1]);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.init = 1'b0;
    b_if.init = 1'b0;
    repeat (3) tick();
    check("rst_a_out", {a_if.clk179, a_if.enp, a_if.enn, a_if.en64, a_if.en15}, 0);
    check("rst_b_out", {b_if.clk179, b_if.enp, b_if.enn, b_if.en64, b_if.en15}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    fork
      begin : thr_a
        int cnt;
        int got;
        for (int i = 1; i <= 219; i++) begin
          tick();
          if (i == 4) begin
            check("a_enp_clk4", a_if.enp, 1);
            check("a_c179_clk4", a_if.clk179, 1);
          end
          if (i == 8) begin
            check("a_enn_clk8", a_if.enn, 1);
            check("a_c179_clk8", a_if.clk179, 0);
          end
          if (i == 12)
            check("a_enp_clk12", a_if.enp, 1);
        end
        // clk 220 carries the 28th enp
        a_if.init = 1'b1;
        tick();
        check("a_enp_28th", a_if.enp, 1);
        check("a_en64_init_wins", a_if.en64, 0);
        a_if.init = 1'b0;
        cnt = 0;
        got = 0;
        for (int j = 0; j < 300; j++) begin
          tick();
          if (a_if.enp) cnt++;
          if (a_if.en64) begin
            got = cnt;
            break;
          end
        end
        check("a_en64_after_init", got, 28);
      end

      begin : thr_b
        int cp, cn, c64, c15, last, bad, first;
        int f64, f15;
        logic was_hi;
        cp = 0; cn = 0; c64 = 0; c15 = 0; last = 0; bad = 0; first = 0;
        for (int i = 1; i <= 50000; i++) begin
          tick();
          if (b_if.enp && b_if.enn) bad++;
          if ((b_if.en64 || b_if.en15) && !b_if.enp) bad++;
          if (b_if.enn && cp == 0) bad++;
          if (b_if.enp) begin
            cp++;
            if (cp == 1) first = i;
            else check_rng("b_enp_gap", i - last, 27, 28);
            last = i;
          end
          if (b_if.enn) cn++;
          if (b_if.en64) c64++;
          if (b_if.en15) c15++;
        end
        check("b_first_enp_clk", first, 14);
        check("b_bad_events", bad, 0);
        check_rng("b_enp_count", cp, 1789, 1790);
        check_rng("b_enn_minus_enp", cn - cp, -1, 1);
        check("b_en64_count", c64, 63);
        check("b_en15_count", c15, 15);

        b_if.init = 1'b1;
        cp = 0; c64 = 0; c15 = 0;
        for (int i = 0; i < 14200 && cp < 500; i++) begin
          tick();
          if (b_if.enp) cp++;
          if (b_if.en64) c64++;
          if (b_if.en15) c15++;
        end
        check("b_init_enp_seen", cp, 500);
        check("b_init_en64", c64, 0);
        check("b_init_en15", c15, 0);
        b_if.init = 1'b0;
        cp = 0; f64 = 0; f15 = 0;
        for (int i = 0; i < 3400 && f15 == 0; i++) begin
          tick();
          if (b_if.enp) cp++;
          if (b_if.en64 && f64 == 0) f64 = cp;
          if (b_if.en15 && f15 == 0) f15 = cp;
        end
        check("b_first_en64_idx", f64, 28);
        check("b_first_en15_idx", f15, 114);

        was_hi = 1'b0;
        for (int i = 0; i < 60 && !was_hi; i++) begin
          tick();
          was_hi = b_if.clk179;
        end
        check("b_phase_hi", was_hi, 1);
        #2;
        rst_b = 1'b1;
        #1;
        check("b_async_rst_out",
              {b_if.clk179, b_if.enp, b_if.enn, b_if.en64, b_if.en15}, 0);
        tick();
        tick();
        rst_b = 1'b0;
        cp = 0; f64 = 0; first = 0; bad = 0;
        for (int i = 1; i <= 900 && f64 == 0; i++) begin
          tick();
          if (first == 0 && (b_if.enp || b_if.enn)) begin
            first = i;
            if (!b_if.enp) bad++;
          end
          if (b_if.enp) cp++;
          if (b_if.en64) f64 = cp;
        end
        check("b_rst_first_clk", first, 14);
        check("b_rst_first_is_enn", bad, 0);
        check("b_rst_en64_idx", f64, 28);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pokey_clk_enable_gen.md
Name: pokey_clk_enable_gen

Overview:
- Generates the POKEY master-clock enables inside the 50 MHz system domain.
- Produces single-cycle pulses on the rising (enp) and falling (enn) edges of a virtual 1.79 MHz clock, using a fractional phase accumulator.
- Derives the 64 kHz and 15 kHz base-clock enables from enp.
- Feeds every audio, timer and serial counter cell chain (cell20 and siblings), which consume enn as their clock enable.

Parameters:
- ACC_W, 24, phase accumulator width in bits.
- INC, 1201096, accumulator increment per clk. Equals round(2 × 1789772.5 / 50e6 × 2^ACC_W). Legal range is 1 to 2^(ACC_W-1)-1.
- DIV64, 28, enp pulses per en64 pulse.
- DIV15, 114, enp pulses per en15 pulse.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  synchronous hold of the base dividers (SKCTL init mode).
- clk179  out  1  level of the virtual 1.79 MHz clock (debug and scope only).
- enp  out  1  one-clk pulse at each virtual rising edge.
- enn  out  1  one-clk pulse at each virtual falling edge.
- en64  out  1  one-clk pulse, coincident with every DIV64-th enp.
- en15  out  1  one-clk pulse, coincident with every DIV15-th enp.

Behaviour:
- Reset (asynchronous, takes effect immediately while high):
  - acc = 0, phase = 0, div64 = 0, div15 = 0.
  - All outputs 0, including clk179.
- Accumulator:
  - Every clk: {carry, acc} = acc + INC, computed in ACC_W+1 bits.
  - acc keeps the low ACC_W bits; it wraps and never saturates.
  - Because INC < 2^(ACC_W-1), at most one carry occurs per clk and carries are never adjacent.
- Phase:
  - On a carry, phase toggles and clk179 follows phase.
  - A carry with phase 0→1 asserts enp for exactly one clk, in the same cycle the registered phase changes.
  - A carry with phase 1→0 asserts enn for exactly one clk.
- Pulse ordering:
  - enp and enn are never high in the same clk.
  - They strictly alternate, and the first pulse after reset is enp.
  - All outputs are registered; no combinational path runs from init to any output.
- Spacing at default INC:
  - Carry spacing is 13 or 14 clks.
  - enp-to-enp period is 27 or 28 clks; long-term mean is 27.9365 clks (1.7897725 MHz).
- Base dividers (advance only on enp):
  - div64 counts 0..DIV64-1. When enp fires with div64 = DIV64-1: div64 → 0 and en64 = 1 that clk.
  - div15 behaves the same with DIV15.
  - When both terminal counts coincide, both pulses fire together.
- init:
  - While high: div64 and div15 are held at 0 and en64/en15 are forced to 0.
  - The accumulator, phase, enp and enn are unaffected.
  - After init falls, the first en64 coincides with the DIV64-th subsequent enp, and the first en15 with the DIV15-th.
  - If init rises in the same clk as a terminal-count enp, init wins: no pulse, and the counter goes to 0.
- Reset mid-operation: everything returns to the reset state at once. After release, the first enp follows the first carry, which occurs ceil(2^ACC_W / INC) clks after release.

Test Plan:
- Reset, then release, INC = 2^(ACC_W-2):
  - carry every 4 clks.
  - first enp on clk 4 after release, enn on clk 8, enp on clk 12.
  - clk179 toggles in the same clks.
- Default parameters, 1 ms window (50000 clks):
  - enp count is 1789 or 1790; enn count is within ±1 of enp.
  - every enp-to-enp gap is 27 or 28; enp and enn are never simultaneous.
- Default parameters, 20000 enp:
  - en64 count = floor(20000/28) = 714; en15 count = floor(20000/114) = 175.
  - every en64 and en15 is coincident with an enp.
- Hold init high for 500 enp, then release:
  - en64 and en15 stay 0 during init; enp/enn cadence is unchanged.
  - first en64 on the 28th enp after release, first en15 on the 114th.
- Assert reset asynchronously mid-period (between clk edges, phase = 1):
  - outputs drop to 0 without waiting for a clk edge.
  - after release, the first pulse is enp, not enn; div64 and div15 restart from 0.
- Raise init on the same clk as the 28th enp:
  - no en64 pulse; div64 reads 0 next clk.
